// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK and traps on unsupported opcodes.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  opcode,
    input  logic        branch_taken,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_we,
    output logic        store_imm,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        illegal_o,
    output logic [2:0]  state_o,
    output logic [31:0] instret_o
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    state_t      state;
    logic [31:0] instret_q;

    function automatic logic is_legal(input logic [4:0] op);
        case (op)
            OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE,
            OP_OP, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: is_legal = 1'b1;
            default:                                   is_legal = 1'b0;
        endcase
    endfunction

    // opcode is held stable by the datapath until the instruction finishes,
    // so it is used directly instead of being latched here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            instret_q <= '0;
        end else begin
            if (pc_we) instret_q <= instret_q + 32'd1;
            case (state)
                S_FETCH:     if (imem_ack) state <= S_DECODE;
                S_DECODE:    state <= is_legal(opcode) ? S_EXECUTE : S_TRAP;
                S_EXECUTE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE:   state <= S_MEM;
                        OP_BRANCH, OP_FENCE: state <= S_FETCH;
                        default:             state <= S_WRITEBACK;
                    endcase
                end
                S_MEM:       if (dmem_ack) state <= (opcode == OP_STORE) ? S_FETCH : S_WRITEBACK;
                S_WRITEBACK: state <= S_FETCH;
                S_TRAP:      state <= S_TRAP;
                default:     state <= S_TRAP;
            endcase
        end
    end

    // Strobes decode from the current state (plus acks); all forced low in reset.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        store_imm = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_DECODE: store_imm = 1'b1;
                S_EXECUTE: begin
                    if (opcode == OP_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_src = branch_taken ? 2'd1 : 2'd0;
                    end else if (opcode == OP_FENCE) begin
                        pc_we = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OP_STORE);
                    pc_we    = dmem_ack && (opcode == OP_STORE);
                end
                S_WRITEBACK: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    case (opcode)
                        OP_LOAD:         wb_sel = 2'd1;
                        OP_JAL, OP_JALR: wb_sel = 2'd2;
                        OP_LUI:          wb_sel = 2'd3;
                        default:         wb_sel = 2'd0;
                    endcase
                    case (opcode)
                        OP_JAL:  pc_src = 2'd1;
                        OP_JALR: pc_src = 2'd2;
                        default: pc_src = 2'd0;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign illegal_o = (state == S_TRAP);
    assign state_o   = state;
    assign instret_o = instret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: walks each instruction class cycle by
// cycle and checks state, strobes, sources, trap and retire count.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  opcode;
    logic        branch_taken;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req, ir_we, store_imm, dmem_req, dmem_we, pc_we, rf_we;
    logic [1:0]  pc_src, wb_sel;
    logic        illegal_o;
    logic [2:0]  state_o;
    logic [31:0] instret_o;

    int checks   = 0;
    int failures = 0;

    // {imem_req, ir_we, store_imm, dmem_req, dmem_we, pc_we, rf_we}
    logic [6:0] strb;
    assign strb = {imem_req, ir_we, store_imm, dmem_req, dmem_we, pc_we, rf_we};

    localparam logic [6:0] ST_NONE   = 7'b0000000;
    localparam logic [6:0] ST_F_WAIT = 7'b1000000;
    localparam logic [6:0] ST_F_ACK  = 7'b1100000;
    localparam logic [6:0] ST_DEC    = 7'b0010000;
    localparam logic [6:0] ST_EX_PC  = 7'b0000010;
    localparam logic [6:0] ST_MEM_LD = 7'b0001000;
    localparam logic [6:0] ST_MEM_ST = 7'b0001100;
    localparam logic [6:0] ST_ST_ACK = 7'b0001110;
    localparam logic [6:0] ST_WB     = 7'b0000011;

    instr_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .store_imm    (store_imm),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .illegal_o    (illegal_o),
        .state_o      (state_o),
        .instret_o    (instret_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's inputs, check the outputs of that cycle, then advance.
    task automatic cyc(input string tag, input logic ia, input logic da, input logic bt,
                       input logic [2:0] exp_state, input logic [6:0] exp_strb,
                       input logic [1:0] exp_pc_src, input logic [1:0] exp_wb_sel);
        imem_ack     = ia;
        dmem_ack     = da;
        branch_taken = bt;
        #1;
        chk({tag, ".state"}, 32'(state_o), 32'(exp_state));
        chk({tag, ".strb"}, 32'(strb), 32'(exp_strb));
        if (exp_strb[1]) chk({tag, ".pc_src"}, 32'(pc_src), 32'(exp_pc_src));
        if (exp_strb[0]) chk({tag, ".wb_sel"}, 32'(wb_sel), 32'(exp_wb_sel));
        tick();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; branch_taken = 1'b1;
        #1;
        chk({tag, ".rst_strb"}, 32'(strb), 32'(ST_NONE));
        tick();
        chk({tag, ".rst_state"}, 32'(state_o), 32'd0);
        chk({tag, ".rst_illegal"}, 32'(illegal_o), 32'd0);
        chk({tag, ".rst_instret"}, instret_o, 32'd0);
        rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        #1;
        chk({tag, ".post_rst_imem_req"}, 32'(imem_req), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; opcode = 5'b00000;
        imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        do_reset("init");

        // OP-IMM, ack on first fetch cycle; stray imem_ack in DECODE ignored.
        opcode = 5'b00100;
        cyc("opimm.f", 1, 0, 0, 3'd0, ST_F_ACK, 0, 0);
        cyc("opimm.d", 1, 0, 0, 3'd1, ST_DEC,   0, 0);
        cyc("opimm.e", 0, 1, 0, 3'd2, ST_NONE,  0, 0);
        cyc("opimm.w", 0, 0, 0, 3'd4, ST_WB,    0, 0);
        #1;
        chk("opimm.end_state", 32'(state_o), 32'd0);
        chk("opimm.instret", instret_o, 32'd1);

        // Branch taken then not taken.
        do_reset("br");
        opcode = 5'b11000;
        cyc("br1.f", 1, 0, 0, 3'd0, ST_F_ACK, 0, 0);
        cyc("br1.d", 0, 0, 0, 3'd1, ST_DEC,   0, 0);
        cyc("br1.e", 0, 0, 1, 3'd2, ST_EX_PC, 1, 0);
        cyc("br2.f", 1, 0, 0, 3'd0, ST_F_ACK, 0, 0);
        cyc("br2.d", 0, 0, 0, 3'd1, ST_DEC,   0, 0);
        cyc("br2.e", 0, 0, 0, 3'd2, ST_EX_PC, 0, 0);
        #1;
        chk("br.end_state", 32'(state_o), 32'd0);
        chk("br.instret", instret_o, 32'd2);

        // LOAD after one fetch wait, dmem_ack delayed 3 cycles.
        opcode = 5'b00000;
        cyc("ld.fw", 0, 1, 0, 3'd0, ST_F_WAIT, 0, 0);
        cyc("ld.f",  1, 0, 0, 3'd0, ST_F_ACK,  0, 0);
        cyc("ld.d",  0, 0, 0, 3'd1, ST_DEC,    0, 0);
        cyc("ld.e",  0, 0, 0, 3'd2, ST_NONE,   0, 0);
        for (int i = 0; i < 3; i++)
            cyc("ld.m_wait", 1, 0, 0, 3'd3, ST_MEM_LD, 0, 0);
        cyc("ld.m_ack", 0, 1, 0, 3'd3, ST_MEM_LD, 0, 0);
        cyc("ld.w",     0, 0, 0, 3'd4, ST_WB,     0, 1);
        #1;
        chk("ld.instret", instret_o, 32'd3);

        // STORE, zero-wait.
        opcode = 5'b01000;
        cyc("st.f",  1, 0, 0, 3'd0, ST_F_ACK,  0, 0);
        cyc("st.d",  0, 0, 0, 3'd1, ST_DEC,    0, 0);
        cyc("st.e",  0, 1, 0, 3'd2, ST_NONE,   0, 0);
        cyc("st.mw", 0, 0, 0, 3'd3, ST_MEM_ST, 0, 0);
        cyc("st.ma", 0, 1, 0, 3'd3, ST_ST_ACK, 0, 0);
        cyc("st.nf", 0, 0, 0, 3'd0, ST_F_WAIT, 0, 0);

        // JALR, JAL, LUI write-back selections.
        opcode = 5'b11001;
        cyc("jalr.f", 1, 0, 0, 3'd0, ST_F_ACK, 0, 0);
        cyc("jalr.d", 0, 0, 0, 3'd1, ST_DEC,   0, 0);
        cyc("jalr.e", 0, 0, 0, 3'd2, ST_NONE,  0, 0);
        cyc("jalr.w", 0, 0, 0, 3'd4, ST_WB,    2, 2);
        opcode = 5'b11011;
        cyc("jal.f", 1, 0, 0, 3'd0, ST_F_ACK, 0, 0);
        cyc("jal.d", 0, 0, 0, 3'd1, ST_DEC,   0, 0);
        cyc("jal.e", 0, 0, 0, 3'd2, ST_NONE,  0, 0);
        cyc("jal.w", 0, 0, 0, 3'd4, ST_WB,    1, 2);
        opcode = 5'b01101;
        cyc("lui.f", 1, 0, 0, 3'd0, ST_F_ACK, 0, 0);
        cyc("lui.d", 0, 0, 0, 3'd1, ST_DEC,   0, 0);
        cyc("lui.e", 0, 0, 0, 3'd2, ST_NONE,  0, 0);
        cyc("lui.w", 0, 0, 0, 3'd4, ST_WB,    0, 3);
        #1;
        chk("mix.instret", instret_o, 32'd7);

        // instret wrap via FENCE retiring from a forced all-ones count.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        opcode = 5'b00011;
        cyc("fence.f", 1, 0, 0, 3'd0, ST_F_ACK, 0, 0);
        cyc("fence.d", 0, 0, 0, 3'd1, ST_DEC,   0, 0);
        cyc("fence.e", 0, 0, 0, 3'd2, ST_EX_PC, 0, 0);
        #1;
        chk("wrap.instret", instret_o, 32'd0);
        chk("wrap.state", 32'(state_o), 32'd0);

        // Reset in the middle of a LOAD's MEM phase.
        opcode = 5'b00000;
        cyc("rmem.f", 1, 0, 0, 3'd0, ST_F_ACK, 0, 0);
        cyc("rmem.d", 0, 0, 0, 3'd1, ST_DEC,   0, 0);
        cyc("rmem.e", 0, 0, 0, 3'd2, ST_NONE,  0, 0);
        #1;
        chk("rmem.in_mem", 32'(state_o), 32'd3);
        do_reset("rmem");

        // Opcode 10001 traps.
        opcode = 5'b10001;
        cyc("t1.f", 1, 0, 0, 3'd0, ST_F_ACK, 0, 0);
        cyc("t1.d", 0, 0, 0, 3'd1, ST_DEC,   0, 0);
        #1;
        chk("t1.state", 32'(state_o), 32'd5);
        chk("t1.illegal", 32'(illegal_o), 32'd1);
        do_reset("t1");

        // Opcode 11100 traps and holds with inputs toggling.
        opcode = 5'b11100;
        cyc("t2.f", 1, 0, 0, 3'd0, ST_F_ACK, 0, 0);
        cyc("t2.d", 0, 0, 0, 3'd1, ST_DEC,   0, 0);
        for (int i = 0; i < 20; i++) begin
            chk("t2.illegal", 32'(illegal_o), 32'd1);
            cyc("t2.hold", 1'(i), 1'(i + 1), 1, 3'd5, ST_NONE, 0, 0);
        end
        chk("t2.instret", instret_o, 32'd0);
        do_reset("t2");
        chk("t2.after_state", 32'(state_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
- REQ-001: clk  input  1  sole clock; all state changes on the rising edge.
- REQ-002: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- REQ-003: opcode  input  5  instruction bits [6:2] from the instruction register; stable from DECODE until the instruction's final state.
- REQ-004: branch_taken  input  1  branch-compare result; valid in EXECUTE.
- REQ-005: imem_ack  input  1  instruction memory has data this cycle.
- REQ-006: dmem_ack  input  1  data memory access completes this cycle.
- REQ-007: imem_req  output  1  instruction fetch request.
- REQ-008: ir_we  output  1  instruction-register load strobe.
- REQ-009: store_imm  output  1  decoder immediate-capture strobe.
- REQ-010: dmem_req, dmem_we  output  1 each  data access request; dmem_we=1 means write.
- REQ-011: pc_we  output  1  PC update strobe.
- REQ-012: pc_src  output  2  PC source: 0 = PC+4, 1 = PC+imm, 2 = ALU result.
- REQ-013: rf_we  output  1  register-file write strobe.
- REQ-014: wb_sel  output  2  write-back source: 0 = ALU, 1 = memory, 2 = PC+4, 3 = imm.
- REQ-015: illegal_o  output  1  sticky trap flag.
- REQ-016: state_o  output  3  current state encoding.
- REQ-017: instret_o  output  32  retired-instruction count.

Function
- REQ-018: States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5; encodings 6 and 7 are unreachable and, if reached, go to TRAP.
- REQ-019: All strobes (ir_we, store_imm, pc_we, rf_we) are Moore/Mealy outputs of the current state and are 0 outside the cases listed below.
- REQ-020: FETCH: imem_req=1; on imem_ack, ir_we=1 for that cycle and next state DECODE; otherwise stay in FETCH.
- REQ-021: DECODE: store_imm=1 for exactly one cycle.
  - Next state EXECUTE if opcode is in {00000, 00011, 00100, 00101, 01000, 01100, 01101, 11000, 11001, 11011}.
  - Otherwise, including 10001 and 11100, next state TRAP.
- REQ-022: EXECUTE, by opcode:
  - LOAD 00000 and STORE 01000: go to MEM.
  - OP 01100, OP-IMM 00100, AUIPC 00101, LUI 01101, JAL 11011, JALR 11001: go to WRITEBACK.
  - BRANCH 11000: pc_we=1, pc_src=1 if branch_taken else 0, go to FETCH.
  - FENCE 00011: pc_we=1, pc_src=0, go to FETCH.
- REQ-023: MEM: dmem_req=1 is held until dmem_ack; dmem_we=1 only for STORE.
  - On ack for LOAD: go to WRITEBACK.
  - On ack for STORE: pc_we=1, pc_src=0, go to FETCH.
- REQ-024: WRITEBACK: rf_we=1 and pc_we=1 for one cycle, then go to FETCH.
  - wb_sel: LOAD=1; JAL and JALR=2; LUI=3; all others=0.
  - pc_src: JAL=1; JALR=2; all others=0.
- REQ-025: TRAP: illegal_o=1; state stays TRAP and all strobes stay 0 until reset.
- REQ-026: instret_o increments by 1 in every cycle where pc_we=1 and wraps from FFFFFFFF to 0.
- REQ-027: An ack arriving while the corresponding request is low is ignored.
- REQ-028: Request lines do not drop before their ack.
- REQ-029: Latency, assuming zero-wait acks: ALU/jump instructions take 4 cycles, branches 3, loads 5, stores 4.

Reset
- REQ-030: While rst_n=0 at a rising edge:
  - state goes to FETCH;
  - illegal_o=0 and instret_o=0;
  - all strobes and requests are 0 during the reset cycle.
- REQ-031: Reset asserted in any state, including mid-MEM and TRAP, takes effect on that edge.
- REQ-032: After rst_n returns high, imem_req=1 in the first cycle.

Verification
- REQ-033: Scenario: OP-IMM with imem_ack on the first FETCH cycle. Required: states 0,1,2,4,0; store_imm high only in DECODE; rf_we=1, wb_sel=0, pc_src=0 in WRITEBACK; instret_o=1.
- REQ-034: Scenario: BRANCH with branch_taken=1, then a second BRANCH with branch_taken=0. Required: pc_we in EXECUTE with pc_src=1, then pc_src=0; rf_we never asserted; instret_o=2.
- REQ-035: Scenario: LOAD with dmem_ack delayed 3 cycles. Required: dmem_req=1 and dmem_we=0 for 4 cycles; then WRITEBACK with wb_sel=1; 8 cycles total.
- REQ-036: Scenario: JALR. Required: WRITEBACK with wb_sel=2 and pc_src=2.
- REQ-037: Scenario: opcode 11100 in DECODE. Required: TRAP next cycle; illegal_o=1 held for 20 cycles with no strobes; rst_n=0 then clears to FETCH with illegal_o=0.
- REQ-038: Scenario: instret_o preloaded to FFFFFFFF by forcing, then an instruction retires. Required: instret_o=00000000.
